// File: rtl/width_serializer_if.sv
// width_serializer_if: wide-word write side and narrow-slice read side of
// the width serializer, bundled as one stream interface.
//   wr_data/wr_cnt/wr_last/wr_vld -> word in,  wr_ready <- accept
//   rd_data/rd_vld/rd_last        <- slice out, rd_ready -> consume
//   busy                          <- word in progress (same as rd_vld)
// slave is the serializer's view; master is the producer/consumer view.
interface width_serializer_if #(
    parameter int unsigned DSIZE = 8,
    parameter int unsigned NSIZE = 4,
    parameter int unsigned CW    = $clog2(NSIZE + 1)
);
    logic [DSIZE*NSIZE-1:0] wr_data;
    logic [CW-1:0]          wr_cnt;
    logic                   wr_last;
    logic                   wr_vld;
    logic                   wr_ready;
    logic [DSIZE-1:0]       rd_data;
    logic                   rd_vld;
    logic                   rd_last;
    logic                   rd_ready;
    logic                   busy;

    modport master (
        output wr_data, wr_cnt, wr_last, wr_vld, rd_ready,
        input  wr_ready, rd_data, rd_vld, rd_last, busy
    );

    modport slave (
        input  wr_data, wr_cnt, wr_last, wr_vld, rd_ready,
        output wr_ready, rd_data, rd_vld, rd_last, busy
    );
endinterface

// File: rtl/width_serializer.sv
// width_serializer: accepts one DSIZE*NSIZE-bit word per handshake and emits
// it as wr_cnt (0 or >NSIZE means NSIZE) slices of DSIZE bits, top slice
// first when MSB_FIRST=1, bottom slice first otherwise.
// Ports:
//   clock - rising-edge clock
//   rst_n - synchronous active-low reset
//   bus   - width_serializer_if.slave (write word side, read slice side)
module width_serializer #(
    parameter int unsigned DSIZE     = 8,
    parameter int unsigned NSIZE     = 4,
    parameter int unsigned MSB_FIRST = 1,
    parameter int unsigned CW        = $clog2(NSIZE + 1)
) (
    input  logic                  clock,
    input  logic                  rst_n,
    width_serializer_if.slave     bus
);
    localparam int unsigned W = DSIZE * NSIZE;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t         state_q;
    logic [W-1:0]   shreg_q;
    logic [CW-1:0]  rem_q;
    logic           last_q;

    logic           rd_vld;
    logic           rem_one;
    logic           accept;
    logic [CW-1:0]  eff_cnt;

    assign rd_vld  = (state_q == SHIFT);
    assign rem_one = (rem_q == CW'(1));

    // Ready while idle, or while the final slice of the current word is
    // being consumed, so the next word loads with no bubble.
    assign bus.wr_ready = rst_n & (~rd_vld | (rem_one & bus.rd_ready));
    assign accept       = bus.wr_vld & bus.wr_ready;

    always_comb begin
        eff_cnt = bus.wr_cnt;
        if (bus.wr_cnt == '0 || bus.wr_cnt > CW'(NSIZE)) begin
            eff_cnt = CW'(NSIZE);
        end
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            rem_q   <= '0;
            last_q  <= 1'b0;
        end else if (accept) begin
            state_q <= SHIFT;
            shreg_q <= bus.wr_data;
            rem_q   <= eff_cnt;
            last_q  <= bus.wr_last;
        end else if (rd_vld && bus.rd_ready) begin
            if (!rem_one) begin
                shreg_q <= (MSB_FIRST != 0) ? (shreg_q << DSIZE) : (shreg_q >> DSIZE);
                rem_q   <= rem_q - CW'(1);
            end else begin
                state_q <= IDLE;
                rem_q   <= '0;
                last_q  <= 1'b0;
            end
        end
    end

    assign bus.rd_vld  = rd_vld;
    assign bus.busy    = rd_vld;
    assign bus.rd_last = rd_vld & last_q & rem_one;
    assign bus.rd_data = (MSB_FIRST != 0) ? shreg_q[W-1 -: DSIZE] : shreg_q[DSIZE-1:0];
endmodule

// File: tb/tb_width_serializer.sv
// tb_width_serializer: directed vectors against two serializers (MSB-first
// and LSB-first). Expected slices are queued when a word is issued and
// popped by per-DUT monitors whenever a slice is consumed.
module tb_width_serializer;
    logic clock;
    logic rst_n;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    width_serializer_if #(.DSIZE(8), .NSIZE(4)) m_if ();
    width_serializer_if #(.DSIZE(8), .NSIZE(4)) l_if ();

    width_serializer #(.DSIZE(8), .NSIZE(4), .MSB_FIRST(1)) u_msb (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (m_if.slave)
    );

    width_serializer #(.DSIZE(8), .NSIZE(4), .MSB_FIRST(0)) u_lsb (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (l_if.slave)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } slice_t;

    slice_t q_m[$];
    slice_t q_l[$];

    int vectors;
    int miscompares;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Monitors: compare every consumed slice against the scoreboard.
    always @(negedge clock) begin
        if (m_if.rd_vld && m_if.rd_ready) begin
            if (q_m.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL msb_unexpected: got slice %h expected none at %0t", m_if.rd_data, $time);
            end else begin
                slice_t e;
                e = q_m.pop_front();
                chk("msb_data", 32'(m_if.rd_data), 32'(e.data));
                chk("msb_last", 32'(m_if.rd_last), 32'(e.last));
            end
        end
        if (l_if.rd_vld && l_if.rd_ready) begin
            if (q_l.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL lsb_unexpected: got slice %h expected none at %0t", l_if.rd_data, $time);
            end else begin
                slice_t e;
                e = q_l.pop_front();
                chk("lsb_data", 32'(l_if.rd_data), 32'(e.data));
                chk("lsb_last", 32'(l_if.rd_last), 32'(e.last));
            end
        end
    end

    // Offers a word and returns #1 after the accepting edge.
    task automatic send(input bit lsb, input logic [31:0] d, input logic [2:0] cnt, input logic last);
        int budget;
        budget = 0;
        if (lsb) begin
            l_if.wr_data = d; l_if.wr_cnt = cnt; l_if.wr_last = last; l_if.wr_vld = 1'b1;
            while (!l_if.wr_ready && budget < 50) begin step(); budget++; end
        end else begin
            m_if.wr_data = d; m_if.wr_cnt = cnt; m_if.wr_last = last; m_if.wr_vld = 1'b1;
            while (!m_if.wr_ready && budget < 50) begin step(); budget++; end
        end
        if (budget >= 50) chk("accept_timeout", 32'(budget), 32'd0);
        step();
        m_if.wr_vld = 1'b0;
        l_if.wr_vld = 1'b0;
    endtask

    task automatic push_m(input logic [7:0] d, input logic last);
        q_m.push_back('{data: d, last: last});
    endtask

    task automatic push_l(input logic [7:0] d, input logic last);
        q_l.push_back('{data: d, last: last});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        m_if.wr_data = '0; m_if.wr_cnt = '0; m_if.wr_last = 1'b0; m_if.wr_vld = 1'b0; m_if.rd_ready = 1'b1;
        l_if.wr_data = '0; l_if.wr_cnt = '0; l_if.wr_last = 1'b0; l_if.wr_vld = 1'b0; l_if.rd_ready = 1'b1;
        repeat (3) step();

        // Reset state
        chk("rst_rd_vld",   32'(m_if.rd_vld),   32'd0);
        chk("rst_rd_last",  32'(m_if.rd_last),  32'd0);
        chk("rst_busy",     32'(m_if.busy),     32'd0);
        chk("rst_rd_data",  32'(m_if.rd_data),  32'd0);
        chk("rst_wr_ready", 32'(m_if.wr_ready), 32'd0);
        chk("rst_lsb_data", 32'(l_if.rd_data),  32'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_wr_ready", 32'(m_if.wr_ready), 32'd1);
        step();

        // MSB-first full word
        push_m(8'hA1, 0); push_m(8'hB2, 0); push_m(8'hC3, 0); push_m(8'hD4, 1);
        send(0, 32'hA1B2C3D4, 3'd0, 1'b1);
        chk("msb_first_slice", 32'(m_if.rd_data), 32'hA1);
        for (int i = 0; i < 4; i++) begin
            chk("msb_vld_run", 32'(m_if.rd_vld), 32'd1);
            chk("msb_last_only_end", 32'(m_if.rd_last), (i == 3) ? 32'd1 : 32'd0);
            step();
        end
        chk("msb_vld_fall", 32'(m_if.rd_vld), 32'd0);

        // LSB-first order
        push_l(8'hD4, 0); push_l(8'hC3, 0); push_l(8'hB2, 0); push_l(8'hA1, 1);
        send(1, 32'hA1B2C3D4, 3'd0, 1'b1);
        chk("lsb_first_slice", 32'(l_if.rd_data), 32'hD4);
        for (int i = 0; i < 4; i++) begin
            chk("lsb_vld_run", 32'(l_if.rd_vld), 32'd1);
            step();
        end
        chk("lsb_vld_fall", 32'(l_if.rd_vld), 32'd0);

        // Partial word
        push_m(8'hA1, 0); push_m(8'hB2, 1);
        send(0, 32'hA1B2C3D4, 3'd2, 1'b1);
        chk("part_wr_ready_a1", 32'(m_if.wr_ready), 32'd0);
        step();
        chk("part_b2_data",     32'(m_if.rd_data),  32'hB2);
        chk("part_wr_ready_b2", 32'(m_if.wr_ready), 32'd1);
        chk("part_rd_last_b2",  32'(m_if.rd_last),  32'd1);
        step();
        chk("part_vld_fall",    32'(m_if.rd_vld),   32'd0);

        // Count above NSIZE means a full word; wr_last=0 never raises rd_last
        push_l(8'h44, 0); push_l(8'h33, 0); push_l(8'h22, 0); push_l(8'h11, 0);
        send(1, 32'h11223344, 3'd7, 1'b0);
        repeat (4) step();
        chk("over_cnt_vld_fall", 32'(l_if.rd_vld), 32'd0);
        push_l(8'h99, 0);
        send(1, 32'h66778899, 3'd1, 1'b0);
        chk("cnt1_no_last", 32'(l_if.rd_last), 32'd0);
        step();
        chk("cnt1_vld_fall", 32'(l_if.rd_vld), 32'd0);

        // Back-to-back words
        for (int i = 1; i <= 8; i++) push_m(8'(i), (i == 8) ? 1'b1 : 1'b0);
        send(0, 32'h01020304, 3'd0, 1'b0);
        m_if.wr_data = 32'h05060708; m_if.wr_cnt = 3'd0; m_if.wr_last = 1'b1; m_if.wr_vld = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k == 4) m_if.wr_vld = 1'b0;
            chk("b2b_vld", 32'(m_if.rd_vld), 32'd1);
            chk("b2b_wr_ready", 32'(m_if.wr_ready), (k == 3 || k == 7) ? 32'd1 : 32'd0);
            step();
        end
        chk("b2b_vld_fall", 32'(m_if.rd_vld), 32'd0);

        // Back-pressure
        push_m(8'hA1, 0); push_m(8'hB2, 0); push_m(8'hC3, 0); push_m(8'hD4, 1);
        send(0, 32'hA1B2C3D4, 3'd0, 1'b1);
        step();
        m_if.rd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_hold_data",     32'(m_if.rd_data),  32'hB2);
            chk("bp_hold_vld",      32'(m_if.rd_vld),   32'd1);
            chk("bp_hold_wr_ready", 32'(m_if.wr_ready), 32'd0);
            step();
        end
        m_if.rd_ready = 1'b1;
        chk("bp_release_data", 32'(m_if.rd_data), 32'hB2);
        step();
        chk("bp_next_c3", 32'(m_if.rd_data), 32'hC3);
        repeat (2) step();
        chk("bp_vld_fall", 32'(m_if.rd_vld), 32'd0);

        // Reset mid-word: D4 must never appear
        push_m(8'hA1, 0); push_m(8'hB2, 0); push_m(8'hC3, 0);
        send(0, 32'hA1B2C3D4, 3'd0, 1'b1);
        step();
        step();
        chk("rst_mid_c3", 32'(m_if.rd_data), 32'hC3);
        rst_n = 1'b0;
        @(posedge clock);
        q_m.delete();
        #1;
        rst_n = 1'b1;
        chk("rst_mid_vld",  32'(m_if.rd_vld),  32'd0);
        chk("rst_mid_data", 32'(m_if.rd_data), 32'd0);
        chk("rst_mid_last", 32'(m_if.rd_last), 32'd0);
        repeat (2) step();
        push_m(8'h05, 0); push_m(8'h06, 0); push_m(8'h07, 1);
        send(0, 32'h05060708, 3'd3, 1'b1);
        chk("post_rst_first", 32'(m_if.rd_data), 32'h05);
        repeat (4) step();
        chk("post_rst_vld_fall", 32'(m_if.rd_vld), 32'd0);

        chk("msb_queue_empty", 32'(q_m.size()), 32'd0);
        chk("lsb_queue_empty", 32'(q_l.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
